// File: rtl/vga_pkg.sv
// Shared constants, pattern encoding and the bounce helper for the VGA test-pattern path.
package vga_pkg;

    localparam int H_VISIBLE    = 640;
    localparam int V_VISIBLE    = 480;
    localparam int VGA_PIPE_LAT = 2;

    typedef enum logic [1:0] {
        PAT_GRID  = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_BOX   = 2'd3
    } pattern_t;

    // Returns {dir_up_next, pos_next}; the direction flips on the update that lands on a limit.
    function automatic logic [10:0] bounce_step(input logic [9:0] pos,
                                                input logic       dir_up,
                                                input logic [9:0] lim);
        logic [9:0] nxt;
        logic       ndir;
        if (dir_up) begin
            if (pos >= lim) begin
                nxt  = lim;
                ndir = 1'b0;
            end else begin
                nxt  = pos + 10'd1;
                ndir = (nxt != lim);
            end
        end else begin
            if (pos == 10'd0) begin
                nxt  = 10'd0;
                ndir = 1'b1;
            end else begin
                nxt  = pos - 10'd1;
                ndir = (nxt == 10'd0);
            end
        end
        return {ndir, nxt};
    endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Timing-in / pixel-out bundle between the VGA timing source and the pattern generator.
interface vga_pattern_gen_if;
    logic       visible;
    logic [9:0] row;
    logic [9:0] col;
    logic       h_sync_in;
    logic       v_sync_in;
    logic       mode_next;
    logic       R;
    logic       G;
    logic       B;
    logic       h_sync_out;
    logic       v_sync_out;
    logic [1:0] mode;
    logic       frame_tick;

    modport master (
        output visible, row, col, h_sync_in, v_sync_in, mode_next,
        input  R, G, B, h_sync_out, v_sync_out, mode, frame_tick
    );

    modport slave (
        input  visible, row, col, h_sync_in, v_sync_in, mode_next,
        output R, G, B, h_sync_out, v_sync_out, mode, frame_tick
    );
endinterface

// File: rtl/vga_box_mover.sv
// Bouncing-box position: x/y step by one on each frame tick and reverse at the edges.
// Single-cycle update when step is high; no backpressure.
module vga_box_mover #(
    parameter logic [9:0] X_MAX = 10'd608,
    parameter logic [9:0] Y_MAX = 10'd448
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    output logic [9:0] x,
    output logic [9:0] y
);
    import vga_pkg::*;

    logic        x_up;
    logic        y_up;
    logic [10:0] x_nxt;
    logic [10:0] y_nxt;

    assign x_nxt = bounce_step(x, x_up, X_MAX);
    assign y_nxt = bounce_step(y, y_up, Y_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x    <= 10'd0;
            y    <= 10'd0;
            x_up <= 1'b1;
            y_up <= 1'b1;
        end else if (step) begin
            {x_up, x} <= x_nxt;
            {y_up, y} <= y_nxt;
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator fed by VGA timing: grid, bars, checker, bouncing box.
// Every output lags its inputs by exactly 2 pixel clocks; pixel-rate stream, no backpressure.
module vga_pattern_gen #(
    parameter int H_VISIBLE       = vga_pkg::H_VISIBLE,
    parameter int V_VISIBLE       = vga_pkg::V_VISIBLE,
    parameter int BOX_SIZE        = 32,
    parameter int FRAMES_PER_MODE = 120,
    parameter int AUTO_CYCLE      = 1
) (
    input  logic              pixel_clk,
    input  logic              reset,
    vga_pattern_gen_if.slave  bus
);
    import vga_pkg::*;

    localparam logic [9:0]  X_MAX      = 10'(H_VISIBLE - BOX_SIZE);
    localparam logic [9:0]  Y_MAX      = 10'(V_VISIBLE - BOX_SIZE);
    localparam logic [9:0]  ROW_LAST   = 10'(V_VISIBLE - 1);
    localparam logic [9:0]  COL_LAST   = 10'(H_VISIBLE - 1);
    localparam logic [7:0]  FRAME_LAST = 8'(FRAMES_PER_MODE - 1);
    localparam logic [10:0] BOX_EXT    = 11'(BOX_SIZE);

    // Stage 1: registered timing inputs
    logic       s1_vis;
    logic [9:0] s1_row;
    logic [9:0] s1_col;
    logic       s1_hs;
    logic       s1_vs;

    // Stage 2: registered pixel and syncs
    logic [2:0] rgb_q;
    logic       hs_q;
    logic       vs_q;
    logic       frame_tick_q;

    logic [1:0] mode_q;
    logic [7:0] frame_cnt;
    logic       pending;

    logic [9:0] box_x;
    logic [9:0] box_y;

    logic       frame_start;
    logic       auto_hit;
    logic       advance;
    logic [2:0] pat;
    logic [2:0] rgb_next;
    logic       grid_hit;
    logic       in_box;
    logic [10:0] col_ext;
    logic [10:0] row_ext;
    logic [10:0] x_end;
    logic [10:0] y_end;

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            s1_vis <= 1'b0;
            s1_row <= 10'd0;
            s1_col <= 10'd0;
            s1_hs  <= 1'b1;
            s1_vs  <= 1'b1;
        end else begin
            s1_vis <= bus.visible;
            s1_row <= bus.row;
            s1_col <= bus.col;
            s1_hs  <= bus.h_sync_in;
            s1_vs  <= bus.v_sync_in;
        end
    end

    // vs_q still holds the previous stage-1 v_sync, so this is the stage-1 falling edge.
    assign frame_start = vs_q & ~s1_vs;
    assign auto_hit    = (AUTO_CYCLE != 0) && (frame_cnt == FRAME_LAST);
    assign advance     = pending | bus.mode_next | auto_hit;

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            mode_q    <= 2'd0;
            frame_cnt <= 8'd0;
            pending   <= 1'b0;
        end else if (frame_start) begin
            if (advance) begin
                mode_q    <= mode_q + 2'd1;
                frame_cnt <= 8'd0;
                pending   <= 1'b0;
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end else if (bus.mode_next) begin
            pending <= 1'b1;
        end
    end

    vga_box_mover #(
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_box (
        .clk  (pixel_clk),
        .rst  (reset),
        .step (frame_tick_q),
        .x    (box_x),
        .y    (box_y)
    );

    // Box bounds in 11 bits so x+BOX_SIZE never wraps.
    assign col_ext = {1'b0, s1_col};
    assign row_ext = {1'b0, s1_row};
    assign x_end   = {1'b0, box_x} + BOX_EXT;
    assign y_end   = {1'b0, box_y} + BOX_EXT;

    always_comb begin
        grid_hit = 1'b0;
        in_box   = 1'b0;
        pat      = 3'b000;
        rgb_next = 3'b000;

        grid_hit = (s1_row[2:0] == 3'd0) || (s1_col[2:0] == 3'd0) ||
                   (s1_row == 10'd0) || (s1_row == ROW_LAST) ||
                   (s1_col == 10'd0) || (s1_col == COL_LAST);
        in_box   = (col_ext >= {1'b0, box_x}) && (col_ext < x_end) &&
                   (row_ext >= {1'b0, box_y}) && (row_ext < y_end);

        case (mode_q)
            PAT_GRID:  pat = grid_hit ? 3'b111 : 3'b000;
            PAT_BARS:  pat = s1_col[9:7];
            PAT_CHECK: pat = {3{s1_row[5] ^ s1_col[5]}};
            PAT_BOX:   pat = in_box ? 3'b100 : 3'b001;
            default:   pat = 3'b000;
        endcase

        rgb_next = s1_vis ? pat : 3'b000;
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            rgb_q        <= 3'b000;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            rgb_q        <= rgb_next;
            hs_q         <= s1_hs;
            vs_q         <= s1_vs;
            frame_tick_q <= frame_start;
        end
    end

    assign bus.R          = rgb_q[2];
    assign bus.G          = rgb_q[1];
    assign bus.B          = rgb_q[0];
    assign bus.h_sync_out = hs_q;
    assign bus.v_sync_out = vs_q;
    assign bus.mode       = mode_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Downstream consumer of vga_controller timing outputs: visible, row, col, h_sync, v_sync.
- Generates 1-bit R/G/B from one of four test patterns: grid, colour bars, checkerboard and bouncing box.
- Cycles patterns automatically every N frames or on a mode_next pulse.
- Delays the syncs so they stay aligned with registered RGB; outputs drive the VGA pins directly.

Parameters:
- H_VISIBLE, 640, visible columns.
- V_VISIBLE, 480, visible rows.
- BOX_SIZE, 32, bouncing-box edge in pixels (power of two).
- FRAMES_PER_MODE, 120, frames before auto-advance (range 1..255).
- AUTO_CYCLE, 1, 1 enables auto-advance, 0 allows mode_next only.

Ports:
- pixel_clk, in, 1, pixel clock (25 MHz).
- reset, in, 1, asynchronous active-high reset.
- visible, in, 1, current pixel is in the active area.
- row, in, 10, current line (0..V_VISIBLE-1 when visible).
- col, in, 10, current column (0..H_VISIBLE-1 when visible).
- h_sync_in, in, 1, horizontal sync from controller, active-low.
- v_sync_in, in, 1, vertical sync from controller, active-low.
- mode_next, in, 1, single-cycle request to advance mode (synchronous to pixel_clk).
- R, out, 1, red.
- G, out, 1, green.
- B, out, 1, blue.
- h_sync_out, out, 1, h_sync_in delayed 2 cycles.
- v_sync_out, out, 1, v_sync_in delayed 2 cycles.
- mode, out, 2, currently displayed pattern.
- frame_tick, out, 1, one-cycle pulse at each frame start.

Behaviour:
- Reset (async assert, sync release):
  - R, G, B = 0; h_sync_out = v_sync_out = 1; mode = 0; frame_tick = 0.
  - Frame counter = 0; pending flag clear.
  - Box at x=0, y=0, direction +x, +y.
- Pipeline:
  - Stage 1 registers visible, row, col and both syncs.
  - Stage 2 computes the pattern from stage-1 values and registers RGB and the syncs.
  - Latency is exactly 2 cycles for every output relative to the inputs.
- Blanking: RGB = 0 whenever stage-1 visible = 0, regardless of mode.
- Frame start: the cycle after stage-1 v_sync falls (1 -> 0).
  - frame_tick pulses high for one cycle.
  - Frame counter increments.
- Mode advance request is raised by either:
  - mode_next = 1, or
  - AUTO_CYCLE = 1 and the frame counter reaches FRAMES_PER_MODE-1 at a frame start.
- Mode advance handling:
  - A request sets the pending flag.
  - mode increments, wrapping 3 -> 0, only at the next frame start. No mid-frame tearing.
  - On that same frame start the frame counter clears to 0 and pending clears.
  - mode_next and an auto request in the same cycle, or multiple mode_next pulses before a frame start, advance by exactly one.
- Modes:
  - 0 grid: RGB = 111 when row[2:0]==0 or col[2:0]==0, plus a border on row 0, row V_VISIBLE-1, col 0 and col H_VISIBLE-1.
  - 1 bars: {R,G,B} = col[9:7] (5 bars of 128 px for 640).
  - 2 checker: RGB = {3{row[5]^col[5]}}.
  - 3 box: RGB = 100 (red) inside [x, x+BOX_SIZE) × [y, y+BOX_SIZE), 001 (blue) elsewhere.
- Box update (once per frame start, all modes, so motion is continuous):
  - x moves ±1. On reaching H_VISIBLE-BOX_SIZE (608) going +, or 0 going −, the direction flips in the same update and the position holds at the limit for that frame.
  - y behaves the same, with limit V_VISIBLE-BOX_SIZE (448).
  - Position never leaves the valid range.
- Arithmetic: x and y are 10-bit unsigned; box compares use 11-bit sums so x+BOX_SIZE cannot overflow.
- Reset mid-frame: all outputs go to reset values immediately; normal operation resumes at the next clock after release, with syncs valid 2 cycles later.

Decomposition:
- Shared package vga_pkg holds:
  - Timing constants H_VISIBLE, V_VISIBLE.
  - Mode enum PAT_GRID=0, PAT_BARS=1, PAT_CHECK=2, PAT_BOX=3.
  - Pipeline latency constant VGA_PIPE_LAT=2.
- One sub-module, vga_box_mover:
  - Owns the x/y position and direction registers.
  - Updated on frame_tick.
  - Outputs x and y.

Test Plan:
- Reset then release, drive visible=0 with syncs high -> R/G/B=0, syncs=1, mode=0, frame_tick never asserted.
- Mode 0, visible=1, row=8, col=3 -> RGB=111 two cycles later; row=9, col=3 -> RGB=000; h_sync_in low pulse appears on h_sync_out exactly 2 cycles later.
- Pulse mode_next mid-frame -> mode stays 0 until the next v_sync fall, becomes 1 the cycle after; then col=384 (col[9:7]=3) -> RGB=011.
- Double mode_next before one frame start -> mode advances by 1 only; mode_next at mode 3 -> wraps to 0.
- AUTO_CYCLE=1, FRAMES_PER_MODE=3, 3 frames -> mode advances at the 3rd frame start; frame counter clears; 3 more frames give the next advance.
- Mode 3, 608 frame starts from reset -> x=608 with direction flipped; next frame x=607; y reaches 448 then decrements; pixel (x, y) red, pixel (x+32, y) blue.
